// File: rtl/mux41_arb_pkg.sv
// Shared constants for the 4-way round-robin arbiter
// driving a mux41 data path select.
package mux41_arb_pkg;

  localparam int NREQ  = 4;
  localparam int CNT_W = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic logic [NREQ-1:0] onehot4(
    input logic [1:0] idx
  );
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin winner search: first set request
// strictly after last_i, wrapping 3 -> 0.
module rr_pick4
  import mux41_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      last_i,
  output logic [1:0]      win_o,
  output logic            vld_o
);

  logic [1:0] idx;

  // Walk from farthest offset to nearest so the
  // nearest set request overwrites the others.
  always_comb begin
    win_o = last_i;
    vld_o = 1'b0;
    idx   = last_i;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last_i + 2'(k);
      if (req_i[idx]) begin
        win_o = idx;
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux41_arb.sv
// Two-state round-robin arbiter with hold limit;
// all outputs come straight from flops.
module mux41_arb
  import mux41_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic            s1,
  output logic            s2,
  output logic            busy,
  output logic            tmo
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(MAX_HOLD - 1);

  logic [0:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            tmo_q, tmo_d;

  logic [1:0] win;
  logic       win_vld;
  logic       own_req;
  logic       rel;

  rr_pick4 u_pick (
    .req_i  (req),
    .last_i (last_q),
    .win_o  (win),
    .vld_o  (win_vld)
  );

  assign own_req = req[last_q];
  assign rel     = !own_req || done ||
                   (cnt_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_GRANT;
          cnt_d   = '0;
          last_d  = win;
          sel_d   = win;
          gnt_d   = onehot4(win);
          busy_d  = 1'b1;
        end
      end
      ST_GRANT: begin
        if (rel) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          // only the hold limit is left as a cause
          tmo_d   = own_req && !done;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt  = gnt_q;
  assign s1   = sel_q[1];
  assign s2   = sel_q[0];
  assign busy = busy_q;
  assign tmo  = tmo_q;

endmodule

// File: tb/tb_mux41_arb.sv
// Bench for mux41_arb: vector table, directed
// corner sequences and a random run against a model.
module tb_mux41_arb;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic       s1, s2, busy, tmo;

  int total = 0;
  int bad   = 0;

  mux41_arb #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .gnt   (gnt),
    .s1    (s1),
    .s2    (s2),
    .busy  (busy),
    .tmo   (tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       tmo;
  } vec_t;

  vec_t tbl[$];

  // model: owner (-1 = none), cycles left, last, sel, tmo
  int m_own, m_left, m_last, m_sel, m_tmo;

  function automatic logic [7:0] dut_out();
    return {gnt, s1, s2, busy, tmo};
  endfunction

  function automatic logic [7:0] pack(
    input logic [3:0] g, input logic [1:0] s,
    input logic b, input logic t);
    return {g, s, b, t};
  endfunction

  function automatic logic [7:0] m_out();
    logic [3:0] g;
    g = (m_own >= 0) ? 4'(1 << m_own) : 4'b0;
    return {g, 2'(m_sel), m_own >= 0, m_tmo != 0};
  endfunction

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b (gnt,s1s2,busy,tmo)",
               nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_own = -1; m_left = 0; m_last = 3;
    m_sel = 0;  m_tmo = 0;
  endtask

  task automatic m_step(input logic [3:0] r,
                        input logic d);
    m_tmo = 0;
    if (m_own < 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (m_own < 0 && r[(m_last + k) % 4]) begin
          m_own  = (m_last + k) % 4;
          m_last = m_own;
          m_sel  = m_own;
          m_left = MH;
        end
      end
    end else begin
      m_left--;
      if (!r[m_own] || d) begin
        m_own = -1;
      end else if (m_left == 0) begin
        m_own = -1;
        m_tmo = 1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; done = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cyc(input logic [3:0] r,
                     input logic d,
                     input string nm);
    req = r; done = d;
    @(posedge clk);
    m_step(r, d);
    @(negedge clk);
    chk(nm, dut_out(), m_out());
  endtask

  task automatic stepx(input logic [3:0] r,
                       input logic d,
                       input logic [7:0] exp,
                       input string nm);
    req = r; done = d;
    @(posedge clk);
    m_step(r, d);
    @(negedge clk);
    chk(nm, dut_out(), exp);
  endtask

  function automatic vec_t mk(
    input logic [3:0] r, input logic d,
    input logic [3:0] g, input logic [1:0] s,
    input logic b, input logic t);
    vec_t v;
    v.req = r; v.done = d; v.gnt = g;
    v.sel = s; v.busy = b; v.tmo = t;
    return v;
  endfunction

  initial begin
    m_reset();
    // full request: order 0,1,2,3,0, release on 2nd cycle
    for (int g = 0; g < 5; g++) begin
      tbl.push_back(mk(4'hf, 0, 4'(1 << (g % 4)),
                       2'(g % 4), 1, 0));
      tbl.push_back(mk(4'hf, 0, 4'(1 << (g % 4)),
                       2'(g % 4), 1, 0));
      tbl.push_back(mk(4'hf, 1, 4'b0, 2'(g % 4), 0, 0));
    end
    // single requester 0, done in 3rd grant cycle
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(4'b0001, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(4'b0001, 1, 4'b0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 4'b0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 1, 4'b0, 0, 0, 0));
    // hold limit on requester 2, then regrant
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(4'b0100, 0, 4'b0100, 2, 1, 0));
    tbl.push_back(mk(4'b0100, 0, 4'b0, 2, 0, 1));
    tbl.push_back(mk(4'b0100, 0, 4'b0100, 2, 1, 0));
    // done coinciding with the limit: no tmo
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(4'b0100, 0, 4'b0100, 2, 1, 0));
    tbl.push_back(mk(4'b0100, 1, 4'b0, 2, 0, 0));
    tbl.push_back(mk(4'b0000, 0, 4'b0, 2, 0, 0));

    // reset state
    #2;
    chk("reset_async", dut_out(), 8'b0);
    @(negedge clk);
    chk("reset_hold", dut_out(), 8'b0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      req = tbl[i].req; done = tbl[i].done;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", i), dut_out(),
          pack(tbl[i].gnt, tbl[i].sel,
               tbl[i].busy, tbl[i].tmo));
    end

    // owner 1 drops while 3 and 0 wait: 3 wins
    do_reset();
    stepx(4'b1010, 0, pack(4'b0010, 1, 1, 0), "drop_g1");
    stepx(4'b1001, 0, pack(4'b0000, 1, 0, 0), "drop_rel");
    stepx(4'b1001, 0, pack(4'b1000, 3, 1, 0), "drop_g3");

    // reset in the middle of a grant to 2
    do_reset();
    stepx(4'b0100, 0, pack(4'b0100, 2, 1, 0), "rst_g2a");
    stepx(4'b0100, 0, pack(4'b0100, 2, 1, 0), "rst_g2b");
    #2 rst_n = 1'b0;
    #1 chk("rst_mid", dut_out(), 8'b0);
    @(negedge clk);
    chk("rst_low", dut_out(), 8'b0);
    rst_n = 1'b1;
    m_reset();
    stepx(4'b1100, 0, pack(4'b0100, 2, 1, 0), "rst_resume");

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic [3:0] r;
      logic       d;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        m_reset();
        #1 chk("rnd_rst", dut_out(), 8'b0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      r = ($urandom_range(0, 3) == 0) ? 4'hf
                                      : 4'($urandom);
      d = ($urandom_range(0, 6) == 0);
      cyc(r, d, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux41_arb.md
MUX41_ARB -- requirements
Module: mux41_arb

Interface
REQ-001 Parameter: MAX_HOLD, default 15, maximum consecutive cycles one requester may hold the grant (legal 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request lines; req[i] asks for data path i (i=0..3 maps to mux41 inputs a,b,c,d).
REQ-005 done  input  1  current owner releases grant; sampled only in GRANT.
REQ-006 gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-007 s1  output  1  mux41 select MSB, registered; {s1,s2} equals granted index.
REQ-008 s2  output  1  mux41 select LSB, registered.
REQ-009 busy  output  1  high while state is GRANT.
REQ-010 tmo  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-011 The FSM SHALL have two states: IDLE and GRANT.
REQ-012 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0 and s1/s2 unchanged.
REQ-013 In IDLE with req!=0, the winner SHALL be the first index with req set, searching from (last+1) mod 4 upward with wrap 3->0.
REQ-014 One cycle after IDLE sees req!=0, gnt SHALL be one-hot on the winner, {s1,s2} SHALL equal the winner index, busy=1, and last SHALL equal the winner.
REQ-015 In GRANT, the grant SHALL be held while req[owner]=1, done=0, and the hold count has not reached MAX_HOLD.
REQ-016 The hold counter SHALL be 8 bits, clear on entry to GRANT, and increment by 1 each GRANT cycle; the grant SHALL last at most exactly MAX_HOLD cycles.
REQ-017 Release SHALL occur on the edge that samples req[owner]=0, done=1, or count==MAX_HOLD-1. On that edge: state IDLE, gnt=0, busy=0, s1/s2 hold the last index.
REQ-018 tmo SHALL be 1 for the single cycle after a release caused only by the count limit, with req[owner]=1 and done=0; otherwise tmo=0.
REQ-019 If done=1 and the count limit coincide, done SHALL take precedence and tmo SHALL stay 0.
REQ-020 There SHALL be exactly one IDLE cycle between consecutive grants, so there is no back-to-back grant.
REQ-021 Changes in req for non-owners during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-022 done sampled in IDLE SHALL be ignored.
REQ-023 gnt SHALL never have more than one bit set, and gnt!=0 SHALL hold if and only if busy=1.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force state=IDLE, gnt=0, s1=0, s2=0, busy=0, tmo=0, count=0, last=3, so index 0 has first priority.
REQ-025 Reset during GRANT SHALL abort the grant without a tmo pulse.
REQ-026 Arbitration SHALL resume on the first rising edge after deassertion.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=0, GRANT=1), the counter width constant (8), and the requester count (4).
REQ-028 A combinational sub-module rr_pick4 SHALL compute the winner index and a valid flag from req and last.
REQ-029 All outputs SHALL be driven directly from flops.

Verification
REQ-030 Reset then req=4'b0001, done pulsed at grant cycle 3 -> gnt=0001, s1s2=00 for 3 cycles; then gnt=0, busy=0, tmo=0.
REQ-031 req=4'b1111 held, done pulsed each grant's 2nd cycle -> grant order 0,1,2,3,0 with one idle cycle between grants; s1s2 follows 00,01,10,11,00.
REQ-032 MAX_HOLD=4, req=4'b0100 held, done=0 -> gnt=0100 for exactly 4 cycles; tmo=1 for one cycle; regrant to 2 after one idle cycle.
REQ-033 MAX_HOLD=4, done=1 on the 4th grant cycle -> release with tmo=0.
REQ-034 Owner 1 drops req mid-grant while req[3]=1 -> release on the next edge; next grant goes to 3, not 0.
REQ-035 rst_n asserted mid-grant of requester 2 -> outputs clear immediately; after deassertion with req=4'b1100, the grant goes to 2.
